// File: rtl/inv_zig_zag.sv
// Zig-zag to raster 8x8 reorder, ping-pong banks; INV_ZZ_TRANSPOSE_EN switches readout to column-major.
// Latency: first word valid the clock after coefficient 63 is accepted; 1 word/clock sustained.
// Backpressure: zz_i_tready low while the write bank is still full; output holds while raster_o_tready is low.
module inv_zig_zag #(
    parameter  int DCT_WIDTH       = 12,
    localparam int DCT_TDATA_WIDTH = ((DCT_WIDTH + 7) / 8) * 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DCT_TDATA_WIDTH-1:0]   zz_i_tdata,
    input  logic                         zz_i_tvalid,
    output logic                         zz_i_tready,
    input  logic                         zz_i_tuser,
    input  logic                         zz_i_tlast,
    output logic [DCT_TDATA_WIDTH-1:0]   raster_o_tdata,
    output logic [DCT_TDATA_WIDTH/8-1:0] raster_o_tstrb,
    output logic [DCT_TDATA_WIDTH/8-1:0] raster_o_tkeep,
    output logic                         raster_o_tvalid,
    input  logic                         raster_o_tready,
    output logic                         raster_o_tuser,
    output logic                         raster_o_tlast
);

    localparam logic [5:0] ZZ2R [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [DCT_WIDTH-1:0] bank_q [2][64];

    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    logic [1:0] full_q, full_d;
    logic [5:0] in_cnt_q, in_cnt_d;
    logic [5:0] out_cnt_q, out_cnt_d;
    logic       usr_acc_q, usr_acc_d;
    logic       lst_acc_q, lst_acc_d;
    logic [1:0] blk_usr_q, blk_usr_d;
    logic [1:0] blk_lst_q, blk_lst_d;

    logic                       wr_fire;
    logic                       rd_fire;
    logic                       rd_vld;
    logic [5:0]                 wr_addr;
    logic [5:0]                 rd_addr;
    logic [DCT_WIDTH-1:0]       rd_word;
    logic [DCT_TDATA_WIDTH-1:0] tdata_unused;

    // Only the low DCT_WIDTH bits carry the coefficient; the padding is don't-care.
    assign tdata_unused = zz_i_tdata;

    assign zz_i_tready = !full_q[wr_sel_q];
    assign wr_fire     = zz_i_tvalid && zz_i_tready;
    assign rd_vld      = full_q[rd_sel_q];
    assign rd_fire     = rd_vld && raster_o_tready;
    assign wr_addr     = ZZ2R[in_cnt_q];

`ifdef INV_ZZ_TRANSPOSE_EN
    assign rd_addr = {out_cnt_q[2:0], out_cnt_q[5:3]};
`else
    assign rd_addr = out_cnt_q;
`endif

    assign rd_word         = bank_q[rd_sel_q][rd_addr];
    assign raster_o_tvalid = rd_vld;
    assign raster_o_tdata  = rd_vld ? DCT_TDATA_WIDTH'(rd_word) : '0;
    assign raster_o_tuser  = rd_vld && blk_usr_q[rd_sel_q] && (out_cnt_q == 6'd0);
    assign raster_o_tlast  = rd_vld && blk_lst_q[rd_sel_q] && (out_cnt_q == 6'd63);
    assign raster_o_tstrb  = '1;
    assign raster_o_tkeep  = '1;

    always_comb begin
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        full_d    = full_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        usr_acc_d = usr_acc_q;
        lst_acc_d = lst_acc_q;
        blk_usr_d = blk_usr_q;
        blk_lst_d = blk_lst_q;

        if (wr_fire) begin
            in_cnt_d = in_cnt_q + 6'd1;
            if (in_cnt_q == 6'd0) begin
                usr_acc_d = zz_i_tuser;
                lst_acc_d = zz_i_tlast;
            end else begin
                lst_acc_d = lst_acc_q | zz_i_tlast;
            end
            if (in_cnt_q == 6'd63) begin
                full_d[wr_sel_q]    = 1'b1;
                blk_usr_d[wr_sel_q] = usr_acc_q;
                blk_lst_d[wr_sel_q] = lst_acc_q | zz_i_tlast;
                wr_sel_d            = !wr_sel_q;
            end
        end

        // Write and read completions always target different banks, so both may land together.
        if (rd_fire) begin
            out_cnt_d = out_cnt_q + 6'd1;
            if (out_cnt_q == 6'd63) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = !rd_sel_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            full_q    <= 2'b00;
            in_cnt_q  <= 6'd0;
            out_cnt_q <= 6'd0;
            usr_acc_q <= 1'b0;
            lst_acc_q <= 1'b0;
            blk_usr_q <= 2'b00;
            blk_lst_q <= 2'b00;
        end else begin
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            full_q    <= full_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            usr_acc_q <= usr_acc_d;
            lst_acc_q <= lst_acc_d;
            blk_usr_q <= blk_usr_d;
            blk_lst_q <= blk_lst_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            bank_q[wr_sel_q][wr_addr] <= zz_i_tdata[DCT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_inv_zig_zag.sv
// Directed bench for inv_zig_zag: zig-zag blocks in, reordered words checked against a scoreboard.
module tb_inv_zig_zag;

    localparam int W  = 12;
    localparam int TW = 16;

    typedef struct packed {
        logic         usr;
        logic         lst;
        logic [W-1:0] dat;
    } word_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [TW-1:0] zz_tdata;
    logic          zz_tvalid, zz_tready, zz_tuser, zz_tlast;
    logic [TW-1:0] ras_tdata;
    logic [1:0]    ras_tstrb, ras_tkeep;
    logic          ras_tvalid, ras_tready, ras_tuser, ras_tlast;

    int tests_run    = 0;
    int tests_failed = 0;

    word_t         in_q[$];
    word_t         exp_q[$];
    logic [TW-1:0] out_log[$];

    int in_prob       = 100;
    int out_prob      = 100;
    int cyc           = 0;
    int in_acc        = 0;
    int out_cnt       = 0;
    int last_in_cyc   = -1;
    int first_out_cyc = -1;
    int gaps          = 0;
    logic          stall_q = 1'b0;
    logic [TW+2:0] held    = '0;

    int zz2r [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

`ifdef INV_ZZ_TRANSPOSE_EN
    int head_exp [10] = '{0, 2, 3, 9, 10, 20, 21, 35, 1, 4};
`else
    int head_exp [10] = '{0, 1, 5, 6, 14, 15, 27, 28, 2, 4};
`endif

    inv_zig_zag #(.DCT_WIDTH(W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .zz_i_tdata      (zz_tdata),
        .zz_i_tvalid     (zz_tvalid),
        .zz_i_tready     (zz_tready),
        .zz_i_tuser      (zz_tuser),
        .zz_i_tlast      (zz_tlast),
        .raster_o_tdata  (ras_tdata),
        .raster_o_tstrb  (ras_tstrb),
        .raster_o_tkeep  (ras_tkeep),
        .raster_o_tvalid (ras_tvalid),
        .raster_o_tready (ras_tready),
        .raster_o_tuser  (ras_tuser),
        .raster_o_tlast  (ras_tlast)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: tdata = k; mode 1: random. tuser noise on k != 0 must be ignored; tlast at lk.
    task automatic add_block(input int mode, input logic usr, input logic lst, input int lk);
        logic [W-1:0] d   [64];
        logic [W-1:0] ras [64];
        int src;
        for (int k = 0; k < 64; k++) begin
            d[k] = (mode == 0) ? W'(k) : W'($urandom);
            ras[zz2r[k]] = d[k];
            in_q.push_back('{usr: (k == 0) ? usr : 1'($urandom_range(1)),
                             lst: lst && (k == lk), dat: d[k]});
        end
        for (int n = 0; n < 64; n++) begin
`ifdef INV_ZZ_TRANSPOSE_EN
            src = (n % 8) * 8 + n / 8;
`else
            src = n;
`endif
            exp_q.push_back('{usr: usr && (n == 0), lst: lst && (n == 63), dat: ras[src]});
        end
    endtask

    task automatic step();
        word_t e;
        @(negedge clk_i);
        zz_tvalid = (in_q.size() > 0) && ($urandom_range(99) < in_prob);
        if (in_q.size() > 0) begin
            zz_tdata = {4'h9, in_q[0].dat};
            zz_tuser = in_q[0].usr;
            zz_tlast = in_q[0].lst;
        end else begin
            zz_tdata = '0;
            zz_tuser = 1'b0;
            zz_tlast = 1'b0;
        end
        ras_tready = ($urandom_range(99) < out_prob);
        #1;
        if (stall_q) check("hold", {ras_tvalid, ras_tuser, ras_tlast, ras_tdata}, held);
        stall_q = ras_tvalid && !ras_tready;
        held    = {ras_tvalid, ras_tuser, ras_tlast, ras_tdata};
        if (!ras_tvalid) check("idle_zero", {ras_tuser, ras_tlast, ras_tdata}, 0);
        if (zz_tvalid && zz_tready) begin
            void'(in_q.pop_front());
            in_acc++;
            last_in_cyc = cyc;
        end
        if (ras_tvalid && ras_tready) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("word", {ras_tuser, ras_tlast, ras_tdata}, {e.usr, e.lst, 4'h0, e.dat});
            end
            out_log.push_back(ras_tdata);
            if (first_out_cyc < 0) first_out_cyc = cyc;
            out_cnt++;
        end else if (first_out_cyc >= 0 && exp_q.size() > 0 && ras_tready) begin
            gaps++;
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(in_q.size() + exp_q.size()), 0);
    endtask

    task automatic mid_reset(input string tag);
        @(posedge clk_i);
        #2;
        rst_i     = 1'b1;
        zz_tvalid = 1'b0;
        #1;
        check({tag, "_vld"}, ras_tvalid, 0);
        check({tag, "_dat"}, {ras_tuser, ras_tlast, ras_tdata}, 0);
        in_q.delete();
        exp_q.delete();
        stall_q = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check({tag, "_rdy"}, zz_tready, 1);
    endtask

    initial begin
        int acc0, out0, n;
        rst_i      = 1'b1;
        zz_tvalid  = 1'b0;
        zz_tdata   = '0;
        zz_tuser   = 1'b0;
        zz_tlast   = 1'b0;
        ras_tready = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_vld", ras_tvalid, 0);
        check("rst_dat", ras_tdata, 0);
        check("rst_side", {ras_tuser, ras_tlast}, 0);
        check("strb_keep", {ras_tstrb, ras_tkeep}, 4'hF);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("rdy_after_rst", zz_tready, 1);

        // Single block, tdata = k, output always ready.
        out_log.delete();
        first_out_cyc = -1;
        add_block(0, 1'b0, 1'b0, 63);
        drain(500);
        check("t1_count", 32'(out_log.size()), 64);
        check("t1_latency", 32'(first_out_cyc - last_in_cyc), 1);
        if (out_log.size() == 64) begin
            for (int i = 0; i < 10; i++) check("t1_head", out_log[i], 32'(head_exp[i]));
            check("t1_tail", out_log[63], 63);
        end

        // Three back-to-back blocks with frame sideband.
        out0 = out_cnt;
        gaps = 0;
        first_out_cyc = -1;
        add_block(1, 1'b1, 1'b0, 63);
        add_block(1, 1'b0, 1'b0, 63);
        add_block(1, 1'b0, 1'b1, 63);
        drain(1000);
        check("t2_count", 32'(out_cnt - out0), 192);
        check("t2_gaps", 32'(gaps), 0);

        // Output stalled for 200 cycles while three blocks are offered.
        out0 = out_cnt;
        acc0 = in_acc;
        out_prob = 0;
        add_block(1, 1'b1, 1'b1, 63);
        add_block(1, 1'b0, 1'b0, 63);
        add_block(1, 1'b0, 1'b1, 63);
        repeat (200) step();
        check("t3_accepted", 32'(in_acc - acc0), 128);
        check("t3_rdy_low", zz_tready, 0);
        check("t3_no_out", 32'(out_cnt - out0), 0);
        out_prob = 100;
        drain(1000);
        repeat (5) step();
        check("t3_count", 32'(out_cnt - out0), 192);

        // Random handshakes on both sides, random data and sideband.
        out0 = out_cnt;
        in_prob  = 50;
        out_prob = 50;
        for (int b = 0; b < 50; b++)
            add_block(1, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(63));
        drain(20000);
        check("t4_count", 32'(out_cnt - out0), 3200);

        // Reset during readout (r = 20) of block A while block B is being written.
        in_prob  = 100;
        out_prob = 100;
        add_block(1, 1'b0, 1'b0, 63);
        add_block(1, 1'b0, 1'b0, 63);
        out0 = out_cnt;
        n = 0;
        while (out_cnt - out0 < 20 && n < 500) begin
            step();
            n++;
        end
        check("t5_reach_r20", 32'(out_cnt - out0), 20);
        mid_reset("t5_rst_rd");

        // Partial block of 30 words is held, then discarded by reset at k = 30.
        add_block(1, 1'b1, 1'b1, 63);
        acc0 = in_acc;
        n = 0;
        while (in_acc - acc0 < 30 && n < 500) begin
            step();
            n++;
        end
        check("t5_reach_k30", 32'(in_acc - acc0), 30);
        in_prob = 0;
        out0 = out_cnt;
        repeat (20) step();
        check("t5_partial_hold", 32'(out_cnt - out0), 0);
        mid_reset("t5_rst_wr");

        // Next full block after reset comes out clean.
        in_prob = 100;
        out_log.delete();
        add_block(0, 1'b1, 1'b1, 63);
        drain(500);
        check("t5_count", 32'(out_log.size()), 64);
        if (out_log.size() == 64) check("t5_head", out_log[2], 32'(head_exp[2]));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
